// File: rtl/multi_buffer.sv
// Rotating N-buffer store: logic side writes one buffer while logic and render sides read others.
// Rotation waits for a render frame boundary when it would collide with the render buffer; optional zero-fill.
module multi_buffer #(
   parameter int DATA_WIDTH    = 1,
   parameter int ADDR_WIDTH    = 16,
   parameter int NUM_BUFS      = 3,
   parameter int CLEAR_ON_SWAP = 0
) (
   input  logic                  clk_130mhz,
   input  logic                  rst_n_in,
   input  logic [ADDR_WIDTH-1:0] logic_addr_r,
   output logic [DATA_WIDTH-1:0] logic_data_r,
   input  logic [ADDR_WIDTH-1:0] logic_addr_w,
   input  logic [DATA_WIDTH-1:0] logic_data_w,
   input  logic                  logic_wr_en,
   input  logic [ADDR_WIDTH-1:0] render_addr_r,
   output logic [DATA_WIDTH-1:0] render_data_r,
   input  logic                  swap_in,
   input  logic                  frame_start_in,
   output logic                  swap_ack_out,
   output logic                  swap_pending_out,
   output logic                  clear_busy_out,
   output logic [1:0]            wr_idx_out,
   output logic [1:0]            rd_idx_out,
   output logic [1:0]            ren_idx_out
);
   localparam int                    IDXW      = (NUM_BUFS > 2) ? 2 : 1;
   localparam int                    DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [1:0]            LAST_IDX  = 2'(NUM_BUFS - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

   clr_state_t            r_state;
   clr_state_t            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clr_cnt;
   logic [1:0]            r_wr_idx;
   logic [1:0]            r_rd_idx;
   logic [1:0]            r_ren_idx;
   logic                  r_pending;
   logic                  r_ack;
   logic [DATA_WIDTH-1:0] r_logic_q;
   logic [DATA_WIDTH-1:0] r_render_q;
   logic [DATA_WIDTH-1:0] r_mem [NUM_BUFS][DEPTH];

   logic [1:0]            w_nxt_idx;
   logic                  w_req;
   logic                  w_idle;
   logic                  w_commit;
   logic                  w_busy;
   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_mem_dat;

   assign w_nxt_idx = (r_wr_idx == LAST_IDX) ? 2'd0 : r_wr_idx + 2'd1;
   assign w_req     = swap_in | r_pending;
   assign w_idle    = (r_state == ST_IDLE);
   assign w_busy    = (r_state == ST_CLEAR);
   // With two buffers nxt always equals the render index, so commits land on frame starts only.
   assign w_commit  = w_req & w_idle & ((w_nxt_idx != r_ren_idx) | frame_start_in);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_commit && (CLEAR_ON_SWAP != 0)) w_state_nxt = ST_CLEAR;
         ST_CLEAR: if (r_clr_cnt == LAST_ADDR) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state   <= ST_IDLE;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_busy ? r_clr_cnt + ONE_ADDR : '0;
      end
   end

   always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_wr_idx  <= 2'd1;
         r_rd_idx  <= 2'd0;
         r_ren_idx <= 2'd0;
         r_pending <= 1'b0;
         r_ack     <= 1'b0;
      end else begin
         if (frame_start_in)
            r_ren_idx <= w_commit ? r_wr_idx : r_rd_idx;
         if (w_commit) begin
            r_rd_idx  <= r_wr_idx;
            r_wr_idx  <= w_nxt_idx;
            r_pending <= 1'b0;
         end else if (w_req) begin
            r_pending <= 1'b1;
         end
         r_ack <= w_commit;
      end
   end

   // The sweep owns the write port; logic writes are dropped while it runs.
   assign w_mem_we   = w_busy | logic_wr_en;
   assign w_mem_addr = w_busy ? r_clr_cnt : logic_addr_w;
   assign w_mem_dat  = w_busy ? '0 : logic_data_w;

   always_ff @(posedge clk_130mhz) begin
      if (w_mem_we)
         r_mem[r_wr_idx[IDXW-1:0]][w_mem_addr] <= w_mem_dat;
   end

   always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_logic_q  <= '0;
         r_render_q <= '0;
      end else begin
         r_logic_q  <= r_mem[r_rd_idx[IDXW-1:0]][logic_addr_r];
         r_render_q <= r_mem[r_ren_idx[IDXW-1:0]][render_addr_r];
      end
   end

   assign logic_data_r     = r_logic_q;
   assign render_data_r    = r_render_q;
   assign swap_ack_out     = r_ack;
   assign swap_pending_out = r_pending;
   assign clear_busy_out   = w_busy;
   assign wr_idx_out       = r_wr_idx;
   assign rd_idx_out       = r_rd_idx;
   assign ren_idx_out      = r_ren_idx;
endmodule
